// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_lvl_ctrl FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  // Default almost-full threshold: two slots short of full.
  function automatic int af_level_default(input int addr_width);
    return (1 << addr_width) - 2;
  endfunction

  // Status word layout for MMIO wrappers.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Register file for the FIFO: one synchronous write port, one asynchronous read port.
// Latency: a write at edge N is visible on rdata_o after edge N; reads are combinational.
// Backpressure: none; the controller gates we_i.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_lvl_ctrl.sv
// Synchronous show-ahead FIFO with level, almost-full/empty thresholds and sticky error flags.
// Latency: write at edge N appears on r_data after edge N; all status is registered-pointer based.
// Backpressure: writes rejected when full unless a read frees a slot in the same cycle (sets overflow).
// Ports: clk, reset_n, wr/w_data, rd/r_data, clr_err; status empty, full, almost_empty,
//        almost_full, level, overflow, underflow.
module fifo_lvl_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = fifo_pkg::af_level_default(ADDR_WIDTH),
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int              PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [PW-1:0]   AF_LVL  = PW'(AF_LEVEL);
  localparam logic [PW-1:0]   AE_LVL  = PW'(AE_LEVEL);

  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_ok, rd_ok;

  // Status is derived from registered state only; no path from wr/rd.
  assign level        = w_ptr_q - r_ptr_q;
  assign empty        = (w_ptr_q == r_ptr_q);
  assign full         = (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]) &&
                        (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]);
  assign almost_empty = (level <= AE_LVL);
  assign almost_full  = (level >= AF_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // When full, a concurrent read frees the slot being written, so the write is taken.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wr_ok) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_ok) r_ptr_d = r_ptr_q + PTR_ONE;
    // A new error in the same cycle as clr_err wins over the clear.
    ovf_d = ovf_q & ~clr_err;
    unf_d = unf_q & ~clr_err;
    if (wr & ~wr_ok) ovf_d = 1'b1;
    if (rd & ~rd_ok) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_ok),
    .waddr_i(w_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i(w_data),
    .raddr_i(r_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o(r_data)
  );

endmodule

// File: tb/tb_fifo_lvl_ctrl.sv
module tb_fifo_lvl_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr, rd, clr_err;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  fifo_lvl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue plus sticky flags.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;

  typedef struct {
    bit            wr, rd, clr;
    logic [DW-1:0] wd;
    int            lvl;
    bit            emp, ful, ae, af, ovf, unf, chk_d;
    logic [DW-1:0] d_exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    bit was_full, was_empty, set_o, set_u;
    wr = w; rd = r; w_data = d; clr_err = c;
    @(posedge clk);
    #1;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    set_o = w && was_full && !r;
    set_u = r && was_empty;
    if (r && !was_empty) void'(mq.pop_front());
    if (w && (!was_full || r)) mq.push_back(d);
    m_ovf = (m_ovf && !c) || set_o;
    m_unf = (m_unf && !c) || set_u;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk_val({tag, "_level"}, int'(level), n);
    chk_val({tag, "_empty"}, int'(empty), int'(n == 0));
    chk_val({tag, "_full"}, int'(full), int'(n == DEPTH));
    chk_val({tag, "_ae"}, int'(almost_empty), int'(n <= 2));
    chk_val({tag, "_af"}, int'(almost_full), int'(n >= 14));
    chk_val({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    chk_val({tag, "_unf"}, int'(underflow), int'(m_unf));
    if (n > 0) chk_val({tag, "_rdata"}, int'(r_data), int'(mq[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [DW-1:0] d;

    // Fill: 16 writes of 0x00..0x0F, head stays 0x00.
    for (int k = 1; k <= 16; k++) begin
      v = '{wr:1, rd:0, clr:0, wd:DW'(k - 1), lvl:k, emp:0, ful:(k == 16), ae:(k <= 2),
            af:(k >= 14), ovf:0, unf:0, chk_d:1, d_exp:8'h00};
      vecs.push_back(v);
    end
    // 17th write is rejected.
    v = '{wr:1, rd:0, clr:0, wd:8'hEE, lvl:16, emp:0, ful:1, ae:0, af:1, ovf:1, unf:0,
          chk_d:1, d_exp:8'h00};
    vecs.push_back(v);
    // Drain: after read i the head is i+1.
    for (int i = 0; i < 16; i++) begin
      v = '{wr:0, rd:1, clr:0, wd:8'h00, lvl:15 - i, emp:(i == 15), ful:0, ae:((15 - i) <= 2),
            af:((15 - i) >= 14), ovf:1, unf:0, chk_d:(i < 15), d_exp:DW'(i + 1)};
      vecs.push_back(v);
    end
    // 17th read is rejected.
    v = '{wr:0, rd:1, clr:0, wd:8'h00, lvl:0, emp:1, ful:0, ae:1, af:0, ovf:1, unf:1,
          chk_d:0, d_exp:8'h00};
    vecs.push_back(v);
    // Clear both flags.
    v = '{wr:0, rd:0, clr:1, wd:8'h00, lvl:0, emp:1, ful:0, ae:1, af:0, ovf:0, unf:0,
          chk_d:0, d_exp:8'h00};
    vecs.push_back(v);
    // Empty with wr&rd: write taken, read rejected.
    v = '{wr:1, rd:1, clr:0, wd:8'hA5, lvl:1, emp:0, ful:0, ae:1, af:0, ovf:0, unf:1,
          chk_d:1, d_exp:8'hA5};
    vecs.push_back(v);

    // Reset.
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #12;
    chk_val("rst_level", int'(level), 0);
    chk_val("rst_empty", int'(empty), 1);
    chk_val("rst_full", int'(full), 0);
    chk_val("rst_ae", int'(almost_empty), 1);
    chk_val("rst_af", int'(almost_full), 0);
    chk_val("rst_ovf", int'(overflow), 0);
    chk_val("rst_unf", int'(underflow), 0);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].wd, vecs[i].clr);
      chk_val($sformatf("v%0d_level", i), int'(level), vecs[i].lvl);
      chk_val($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].emp));
      chk_val($sformatf("v%0d_full", i), int'(full), int'(vecs[i].ful));
      chk_val($sformatf("v%0d_ae", i), int'(almost_empty), int'(vecs[i].ae));
      chk_val($sformatf("v%0d_af", i), int'(almost_full), int'(vecs[i].af));
      chk_val($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
      chk_val($sformatf("v%0d_unf", i), int'(underflow), int'(vecs[i].unf));
      if (vecs[i].chk_d) chk_val($sformatf("v%0d_rdata", i), int'(r_data), int'(vecs[i].d_exp));
    end

    // Full with simultaneous wr&rd: level holds, head advances, 0x55 comes out last.
    drive(0, 0, 8'h00, 1);
    for (int k = 0; k < 15; k++) drive(1, 0, DW'(8'h10 + k), 0);
    check_model("fill2");
    drive(1, 1, 8'h55, 0);
    chk_val("fullrw_level", int'(level), 16);
    chk_val("fullrw_rdata", int'(r_data), 8'h10);
    chk_val("fullrw_ovf", int'(overflow), 0);
    check_model("fullrw");
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, 8'h00, 0);
      check_model($sformatf("drain2_%0d", k));
    end
    chk_val("last_word", int'(r_data), 8'h55);
    drive(0, 1, 8'h00, 0);
    check_model("drain2_end");

    // Sustained wr&rd at level 3 for 40 cycles; both pointers wrap.
    for (int k = 0; k < 3; k++) drive(1, 0, DW'($urandom_range(0, 255)), 0);
    for (int k = 0; k < 40; k++) begin
      d = DW'($urandom_range(0, 255));
      drive(1, 1, d, 0);
      chk_val($sformatf("stream%0d_level", k), int'(level), 3);
      check_model($sformatf("stream%0d", k));
    end

    // Reset mid-stream at level 7 with underflow set.
    for (int k = 0; k < 4; k++) drive(0, 1, 8'h00, 0);
    for (int k = 0; k < 7; k++) drive(1, 0, DW'(8'h60 + k), 0);
    check_model("pre_rst");
    #3 reset_n = 1'b0;
    #1;
    chk_val("midrst_level", int'(level), 0);
    chk_val("midrst_empty", int'(empty), 1);
    chk_val("midrst_unf", int'(underflow), 0);
    chk_val("midrst_ovf", int'(overflow), 0);
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #10 reset_n = 1'b1;
    drive(1, 0, 8'h3C, 0);
    chk_val("post_rst_rdata", int'(r_data), 8'h3C);
    check_model("post_rst");

    // clr_err together with a new overflow: the set wins.
    for (int k = 0; k < 15; k++) drive(1, 0, DW'(8'h80 + k), 0);
    drive(1, 0, 8'hFF, 0);
    check_model("ovf_set");
    drive(1, 0, 8'hFE, 1);
    chk_val("clr_vs_set_ovf", int'(overflow), 1);
    check_model("clr_vs_set");
    drive(0, 0, 8'h00, 1);
    chk_val("clr_only_ovf", int'(overflow), 0);
    check_model("clr_only");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
